// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I datapath: control-word fields
// and the RV32I major opcodes the external controller decodes.
package mc_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// x0 is hardwired to zero; reset clears every register.
module mc_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents when read and write hit the same register.
    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I datapath with a shared instruction/data memory port.
// Sequencing comes from an external controller; mem_ready low freezes all state.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic            pc_write,
    input  logic            adr_src,
    input  logic            ir_write,
    input  logic            reg_write,
    input  logic [1:0]      alu_src_a,
    input  logic [1:0]      alu_src_b,
    input  logic [2:0]      alu_func,
    input  logic [2:0]      imm_src,
    input  logic [1:0]      result_src,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            zero
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, a_q, b_q, aluout_q;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] src_a, src_b, alu_result, result, imm;
    logic [31:0]     imm32;

    mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write && mem_ready),
        .raddr1 (ir_q[15 +: AW]),
        .raddr2 (ir_q[20 +: AW]),
        .waddr  (ir_q[7 +: AW]),
        .wdata  (result),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        imm32 = '0;
        case (imm_src)
            IMM_I:   imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            IMM_U:   imm32 = {ir_q[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    always_comb begin
        case (alu_src_a)
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = oldpc_q;
            SRCA_A:     src_a = a_q;
            default:    src_a = '0;
        endcase
        case (alu_src_b)
            SRCB_B:    src_b = b_q;
            SRCB_IMM:  src_b = imm;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_func)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result = XLEN'(src_a < src_b);
            ALU_SLL:  alu_result = src_a << src_b[4:0];
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        case (result_src)
            RES_ALUOUT: result = aluout_q;
            RES_MDR:    result = mdr_q;
            RES_ALU:    result = alu_result;
            default:    result = imm;
        endcase
    end

    // OldPC captures the PC of the instruction being fetched, for branch targets.
    always_comb begin
        pc_d    = pc_q;
        oldpc_d = oldpc_q;
        ir_d    = ir_q;
        if (pc_write) begin
            pc_d = result;
        end
        if (ir_write) begin
            ir_d    = mem_rdata;
            oldpc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else if (mem_ready) begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            ir_q     <= ir_d;
            mdr_q    <= mem_rdata;
            a_q      <= rs1_data;
            b_q      <= rs2_data;
            aluout_q <= alu_result;
        end
    end

    assign mem_addr  = adr_src ? result : pc_q;
    assign mem_wdata = b_q;
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7b5  = ir_q[30];
    assign zero      = (alu_result == '0);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: drives control words like a multi-cycle controller
// and checks port-visible state against a register/memory model via a scoreboard queue.
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, memReady, pcWrite, adrSrc, irWrite, regWrite;
    logic [1:0]  aluSrcA, aluSrcB, resultSrc;
    logic [2:0]  aluFunc, immSrc;
    logic [31:0] memRdata, memAddr, memWdata, memRdata16, memAddr16, memWdata16;
    logic [6:0]  opcode, opcode16;
    logic [2:0]  funct3, funct3_16;
    logic        funct7b5, funct7b5_16, zero, zero16;

    logic [31:0] mem [256];
    logic [31:0] rf32 [32];
    logic [31:0] rf16 [16];
    logic [31:0] expPc;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sbEntry_t;
    sbEntry_t sbQ[$];

    int checks = 0;
    int errors = 0;

    assign memRdata   = mem[memAddr[9:2]];
    assign memRdata16 = mem[memAddr16[9:2]];

    mc_datapath #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .mem_rdata(memRdata), .mem_ready(memReady),
        .pc_write(pcWrite), .adr_src(adrSrc), .ir_write(irWrite), .reg_write(regWrite),
        .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_func(aluFunc), .imm_src(immSrc),
        .result_src(resultSrc), .mem_addr(memAddr), .mem_wdata(memWdata),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero)
    );

    mc_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) dut16 (
        .clk(clk), .rst(rst), .mem_rdata(memRdata16), .mem_ready(memReady),
        .pc_write(pcWrite), .adr_src(adrSrc), .ir_write(irWrite), .reg_write(regWrite),
        .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_func(aluFunc), .imm_src(immSrc),
        .result_src(resultSrc), .mem_addr(memAddr16), .mem_wdata(memWdata16),
        .opcode(opcode16), .funct3(funct3_16), .funct7b5(funct7b5_16), .zero(zero16)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] aluModel(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
        case (fn)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return a << b[4:0];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pcw, input logic adr, input logic irw,
                                 input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [2:0] fn, input logic [2:0] is,
                                 input logic [1:0] rs);
        pcWrite = pcw; adrSrc = adr; irWrite = irw; regWrite = rw;
        aluSrcA = sa; aluSrcB = sb; aluFunc = fn; immSrc = is; resultSrc = rs;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, SRCA_PC, SRCB_B, ALU_ADD, IMM_I, RES_ALUOUT);
    endtask

    task automatic pushExp(input string tag, input logic [31:0] val);
        sbEntry_t e;
        e.tag = tag;
        e.val = val;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        sbEntry_t e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_underflow: observed %h with no expected value", obs);
        end else begin
            e = sbQ.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic modelWrite(input logic [4:0] rd, input logic [31:0] val);
        if (rd != 5'd0) rf32[rd] = val;
        if (rd[3:0] != 4'd0) rf16[rd[3:0]] = val;
    endtask

    task automatic modelReset();
        foreach (rf32[i]) rf32[i] = '0;
        foreach (rf16[i]) rf16[i] = '0;
        expPc = 32'h100;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic advance);
        mem[expPc[9:2]] = instr;
        applyStimulus(advance, 0, 1, 0, SRCA_PC, SRCB_FOUR, ALU_ADD, IMM_I, RES_ALU);
        tick();
        if (advance) expPc = expPc + 32'd4;
    endtask

    // Reads a register through the B latch onto mem_wdata without moving the PC.
    task automatic readReg(input logic [4:0] r);
        pushExp($sformatf("x%0d", r), rf32[r]);
        pushExp($sformatf("x%0d_nregs16", r), rf16[r[3:0]]);
        fetch(encS(12'd0, r, 5'd0, 3'b010), 1'b0);
        idle();
        tick();
        checkOutput(memWdata);
        checkOutput(memWdata16);
    endtask

    task automatic execOpImm(input logic [31:0] instr, input logic [4:0] rd,
                             input logic [31:0] val);
        fetch(instr, 1'b1);
        idle();
        tick();
        applyStimulus(0, 0, 0, 0, SRCA_A, SRCB_IMM, ALU_ADD, IMM_I, RES_ALU);
        tick();
        applyStimulus(0, 0, 0, 1, SRCA_PC, SRCB_B, ALU_ADD, IMM_I, RES_ALUOUT);
        tick();
        modelWrite(rd, val);
        idle();
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        modelReset();
        rst = 1'b1;
        memReady = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        idle();

        $display("[TB] reset state");
        pushExp("pc_reset", 32'h100);        checkOutput(memAddr);
        pushExp("opcode_reset", 32'h0);      checkOutput({25'b0, opcode});
        pushExp("funct3_reset", 32'h0);      checkOutput({29'b0, funct3});
        pushExp("funct7b5_reset", 32'h0);    checkOutput({31'b0, funct7b5});
        pushExp("wdata_reset", 32'h0);       checkOutput(memWdata);
        pushExp("zero_reset", 32'h0);        checkOutput({31'b0, zero});
        pushExp("opcode16_reset", 32'h0);    checkOutput({25'b0, opcode16});
        pushExp("funct3_16_reset", 32'h0);   checkOutput({29'b0, funct3_16});
        pushExp("funct7b5_16_reset", 32'h0); checkOutput({31'b0, funct7b5_16});
        pushExp("zero16_reset", 32'h0);      checkOutput({31'b0, zero16});
        for (int r = 0; r < 32; r++) readReg(5'(r));

        $display("[TB] addi x1,x0,5");
        execOpImm(32'h00500093, 5'd1, 32'd5);
        pushExp("pc_after_addi", 32'h104);   checkOutput(memAddr);
        readReg(5'd1);

        $display("[TB] build 0xDEADBEEF in x1, sw/lw round trip");
        fetch(encU(20'hDEADC, 5'd1, OP_LUI), 1'b1);
        idle();
        tick();
        applyStimulus(0, 0, 0, 1, SRCA_PC, SRCB_B, ALU_ADD, IMM_U, RES_IMM);
        tick();
        modelWrite(5'd1, 32'hDEADC000);
        execOpImm(encI(12'hEEF, 5'd1, 3'b000, 5'd1, OP_OPIMM), 5'd1, 32'hDEADBEEF);
        readReg(5'd1);

        fetch(encS(12'd8, 5'd1, 5'd0, 3'b010), 1'b1);
        idle();
        tick();
        applyStimulus(0, 0, 0, 0, SRCA_A, SRCB_IMM, ALU_ADD, IMM_S, RES_ALU);
        tick();
        applyStimulus(0, 1, 0, 0, SRCA_PC, SRCB_B, ALU_ADD, IMM_S, RES_ALUOUT);
        pushExp("sw_addr", 32'h8);           checkOutput(memAddr);
        pushExp("sw_wdata", 32'hDEADBEEF);   checkOutput(memWdata);
        mem[memAddr[9:2]] = memWdata;
        tick();

        fetch(encI(12'd8, 5'd0, 3'b010, 5'd2, OP_LOAD), 1'b1);
        idle();
        pushExp("lw_funct3", 32'd2);         checkOutput({29'b0, funct3});
        tick();
        applyStimulus(0, 0, 0, 0, SRCA_A, SRCB_IMM, ALU_ADD, IMM_I, RES_ALU);
        tick();
        applyStimulus(0, 1, 0, 0, SRCA_PC, SRCB_B, ALU_ADD, IMM_I, RES_ALUOUT);
        pushExp("lw_addr", 32'h8);           checkOutput(memAddr);
        tick();
        applyStimulus(0, 0, 0, 1, SRCA_PC, SRCB_B, ALU_ADD, IMM_I, RES_MDR);
        tick();
        modelWrite(5'd2, 32'hDEADBEEF);
        idle();
        readReg(5'd2);

        $display("[TB] index truncation and x0");
        execOpImm(encI(12'd9, 5'd0, 3'b000, 5'd17, OP_OPIMM), 5'd17, 32'd9);
        readReg(5'd17);
        readReg(5'd1);
        execOpImm(encI(12'd7, 5'd0, 3'b000, 5'd0, OP_OPIMM), 5'd0, 32'd7);
        readReg(5'd0);

        $display("[TB] memory stall during fetch");
        mem[expPc[9:2]] = encU(20'h12345, 5'd3, OP_LUI);
        memReady = 1'b0;
        applyStimulus(1, 0, 1, 0, SRCA_PC, SRCB_FOUR, ALU_ADD, IMM_I, RES_ALU);
        tick();
        tick();
        tick();
        pushExp("stall_pc_hold", expPc);             checkOutput(memAddr);
        pushExp("stall_ir_hold", {25'b0, OP_STORE}); checkOutput({25'b0, opcode});
        memReady = 1'b1;
        tick();
        expPc = expPc + 32'd4;
        idle();
        pushExp("stall_pc_update", expPc);           checkOutput(memAddr);
        pushExp("stall_ir_update", {25'b0, OP_LUI}); checkOutput({25'b0, opcode});
        tick();
        pushExp("stall_pc_once", expPc);             checkOutput(memAddr);
        applyStimulus(0, 0, 0, 1, SRCA_PC, SRCB_B, ALU_ADD, IMM_U, RES_IMM);
        tick();
        modelWrite(5'd3, 32'h12345000);
        idle();
        readReg(5'd3);

        $display("[TB] ALU function sweep");
        fetch({7'b0, 5'd3, 5'd1, 3'b000, 5'd0, OP_OP}, 1'b1);
        idle();
        tick();
        for (int f = 0; f < 8; f++) begin
            applyStimulus(0, 1, 0, 0, SRCA_A, SRCB_B, 3'(f), IMM_I, RES_ALU);
            pushExp($sformatf("alu%0d_regB", f), aluModel(3'(f), rf32[1], rf32[3]));
            checkOutput(memAddr);
            applyStimulus(0, 1, 0, 0, SRCA_A, SRCB_IMM, 3'(f), IMM_I, RES_ALU);
            pushExp($sformatf("alu%0d_imm", f), aluModel(3'(f), rf32[1], 32'd3));
            checkOutput(memAddr);
        end
        idle();

        $display("[TB] beq x0,x0,-8 at 0x20");
        fetch(encI(12'h020, 5'd0, 3'b000, 5'd0, OP_OPIMM), 1'b0);
        applyStimulus(1, 0, 0, 0, SRCA_ZERO, SRCB_B, ALU_ADD, IMM_I, RES_IMM);
        tick();
        expPc = 32'h20;
        idle();
        pushExp("jump_pc", 32'h20);          checkOutput(memAddr);
        fetch(encB(13'h1FF8, 5'd0, 5'd0, 3'b000), 1'b1);
        applyStimulus(0, 0, 0, 0, SRCA_OLDPC, SRCB_IMM, ALU_ADD, IMM_B, RES_ALU);
        tick();
        applyStimulus(1, 0, 0, 0, SRCA_A, SRCB_B, ALU_SUB, IMM_B, RES_ALUOUT);
        pushExp("beq_zero", 32'h1);          checkOutput({31'b0, zero});
        tick();
        expPc = 32'h18;
        idle();
        pushExp("beq_target", 32'h18);       checkOutput(memAddr);

        $display("[TB] reset mid-instruction during a stall");
        mem[expPc[9:2]] = 32'h00500093;
        memReady = 1'b0;
        rst = 1'b1;
        applyStimulus(1, 0, 1, 1, SRCA_PC, SRCB_FOUR, ALU_ADD, IMM_I, RES_ALU);
        tick();
        rst = 1'b0;
        memReady = 1'b1;
        modelReset();
        idle();
        pushExp("rst_pc", 32'h100);          checkOutput(memAddr);
        pushExp("rst_opcode", 32'h0);        checkOutput({25'b0, opcode});
        pushExp("rst_wdata", 32'h0);         checkOutput(memWdata);
        readReg(5'd1);
        readReg(5'd2);

        checks++;
        assert (sbQ.size() == 0)
        else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sbQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
